// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - 8-digit multiplexed seven-segment scanner for a 32-bit hex word
// Optional leading-zero suppression: define HEX_DISPLAY_LZS_EN.
module hex_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        external_clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] value,
  input  logic [7:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    snap_dp_q, snap_dp_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_wrap;
  logic          show;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    slot_wrap = (cnt_q == CNT_LAST);

    if (ena) begin
      cnt_d = slot_wrap ? '0 : cnt_q + CW'(1);
      if (slot_wrap) begin
        digit_d = digit_q + 3'd1;
      end
      // Snapshot lands while digit 0 is still blanked, so no digit mixes two words.
      if (cnt_q == '0 && digit_q == 3'd0) begin
        snap_d    = value;
        snap_dp_d = dp_in;
      end
    end

    state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
  end

  always_comb begin
    an_d         = 8'hFF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = ena && slot_wrap && (digit_q == 3'd7);
    nibble       = snap_q[{digit_q, 2'b00} +: 4];
    show         = ena && (state_q == ST_DRIVE);
`ifdef HEX_DISPLAY_LZS_EN
    // Everything from this digit upward is zero: treat it as a leading zero.
    if (digit_q != 3'd0 && (snap_q >> {digit_q, 2'b00}) == 32'd0) begin
      show = 1'b0;
    end
`endif
    if (show) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = hex_to_seg(nibble);
      dp_d  = ~snap_dp_q[digit_q];
    end
  end

  always_ff @(posedge external_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      digit_q      <= 3'd0;
      snap_q       <= 32'd0;
      snap_dp_q    <= 8'd0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      snap_q       <= snap_d;
      snap_dp_q    <= snap_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner
// Exercises the HEX_DISPLAY_LZS_EN variant when that macro is defined.
module tb_hex_display_scanner;

  logic        external_clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;

  int checks   = 0;
  int errors   = 0;
  int e        = 0;
  int fd_count = 0;
  int fd_base  = 0;

  logic [6:0] exp_frame [8];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  hex_display_scanner #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .external_clk(external_clk),
    .rst         (rst),
    .ena         (ena),
    .value       (value),
    .dp_in       (dp_in),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 external_clk = ~external_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // e counts enabled, out-of-reset edges since the last reset release.
  task automatic tick();
    logic en_s;
    logic rst_s;
    en_s  = ena;
    rst_s = rst;
    @(posedge external_clk);
    #1;
    if (en_s && rst_s) e++;
    if (frame_done === 1'b1) fd_count++;
  endtask

  task automatic tick_to(input int target);
    int guard;
    guard = 0;
    while (e < target && guard < 2000) begin
      tick();
      guard++;
    end
    if (e != target) chk("tick_to_bound", e, target);
  endtask

  initial begin
    exp_frame = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    rst   = 1'b0;
    ena   = 1'b0;
    value = 32'd0;
    dp_in = 8'd0;

    repeat (3) @(posedge external_clk);
    #1;
    chk("reset_an", an, 8'hFF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_fd", frame_done, 1'b0);

    rst = 1'b1;
    ena = 1'b1;
    e   = 0;
    tick();
    chk("start_blank_an", an, 8'hFF);
    tick();
    chk("start_d0_an", an, 8'hFE);
    chk("start_d0_seg", seg, 7'h40);
    chk("start_d0_dp", dp, 1'b1);

    value = 32'h89ABCDEF;
    dp_in = 8'h01;
    tick_to(31);
    chk("fd_before_wrap", frame_done, 1'b0);
    tick_to(32);
    chk("fd_at_wrap", frame_done, 1'b1);
    fd_base = fd_count;
    tick_to(33);
    chk("snap_edge_blank", an, 8'hFF);

    for (int d = 0; d < 8; d++) begin
      if (d > 0) begin
        tick_to(33 + 4 * d);
        chk("frame_slot_blank", an, 8'hFF);
      end
      tick_to(34 + 4 * d);
      exp_an = ~(8'b1 << d);
      exp_dp = (d == 0) ? 1'b0 : 1'b1;
      chk("frame_an", an, exp_an);
      chk("frame_seg", seg, exp_frame[d]);
      chk("frame_dp", dp, exp_dp);
      if (d == 3) value = 32'h12345678;
    end
    tick_to(64);
    chk("fd_second_wrap", frame_done, 1'b1);
    chk("fd_once_per_frame", fd_count - fd_base, 1);

    tick_to(66);
    chk("next_frame_an", an, 8'hFE);
    chk("next_frame_seg", seg, 7'h00);

    tick_to(86);
    chk("d5_an", an, 8'hDF);
    chk("d5_seg", seg, 7'h30);
    fd_base = fd_count;
    ena = 1'b0;
    tick();
    chk("disable_blank_an", an, 8'hFF);
    chk("disable_blank_seg", seg, 7'h7F);
    repeat (9) tick();
    chk("disable_hold_an", an, 8'hFF);
    chk("disable_no_fd", fd_count - fd_base, 0);

    ena = 1'b1;
    tick();
    chk("resume_an_a", an, 8'hDF);
    chk("resume_seg_a", seg, 7'h30);
    tick();
    chk("resume_an_b", an, 8'hDF);
    tick();
    chk("resume_slot_end", an, 8'hFF);
    tick();
    chk("d6_an", an, 8'hBF);
    chk("d6_seg", seg, 7'h24);

    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    e   = 0;
    tick();
    chk("restart_blank", an, 8'hFF);
    tick();
    chk("restart_an", an, 8'hFE);
    chk("restart_seg", seg, 7'h00);
    chk("restart_dp", dp, 1'b0);

    value = 32'h000000A0;
    dp_in = 8'h00;
    tick_to(33);
    for (int d = 0; d < 8; d++) begin
      exp_seg = (d == 1) ? 7'h08 : 7'h40;
      exp_an  = ~(8'b1 << d);
`ifdef HEX_DISPLAY_LZS_EN
      if (d >= 2) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end
`endif
      tick_to(34 + 4 * d);
      chk("lz_an_early", an, exp_an);
      chk("lz_seg_early", seg, exp_seg);
      chk("lz_dp", dp, 1'b1);
      tick_to(36 + 4 * d);
      chk("lz_an_late", an, exp_an);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
